// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one op in flight,
// responses tagged with requester id. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (r0 wins ties).
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [CTRL_W-1:0] r0_ctrl,
  input  logic [WIDTH-1:0]  r0_a,
  input  logic [WIDTH-1:0]  r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [CTRL_W-1:0] r1_ctrl,
  input  logic [WIDTH-1:0]  r1_a,
  input  logic [WIDTH-1:0]  r1_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_oper1,
  output logic [WIDTH-1:0]  alu_oper2,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_reg;
  logic       id_reg;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic       grant_any;
  logic       grant_id;
  logic       accept;

  assign req_valid = {r1_valid, r0_valid};

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = |req_valid;
    grant_id  = (req_valid == 2'b10);
  end
`else
  logic last_grant_reg;

  // Tie goes to whoever did not win last; reset value 1 lets r0 win first.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = 1'b0;
    if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end else if (req_valid == 2'b11) begin
      grant_id = ~last_grant_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      last_grant_reg <= grant_id;
    end
  end
`endif

  assign accept = grant_any && (state_reg == IDLE);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = accept && req_valid[gi] && (grant_id == (gi == 1));
  end

  assign r0_ready = req_ready[0];
  assign r1_ready = req_ready[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      id_reg       <= 1'b0;
      alu_ctrl     <= '0;
      alu_oper1    <= '0;
      alu_oper2    <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            alu_ctrl  <= grant_id ? r1_ctrl : r0_ctrl;
            alu_oper1 <= grant_id ? r1_a : r0_a;
            alu_oper2 <= grant_id ? r1_b : r0_b;
            id_reg    <= grant_id;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          // ALU is combinational off the alu_* registers, so its outputs are settled here.
          rsp_result   <= alu_result;
          rsp_overflow <= alu_overflow;
          rsp_zero     <= alu_zero;
          rsp_id       <= id_reg;
          rsp_valid    <= 1'b1;
          state_reg    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural combinational ALU.
// Build with ALU_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_valid, r1_valid;
  logic              r0_ready, r1_ready;
  logic [CTRL_W-1:0] r0_ctrl, r1_ctrl;
  logic [WIDTH-1:0]  r0_a, r0_b, r1_a, r1_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_oper1, alu_oper2, alu_result;
  logic              alu_overflow, alu_zero;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_zero;
  logic [WIDTH-1:0]  rsp_result;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic [34:0] exp_q[$];
  logic [34:0] rsp_log[$];
  int          grant_log[$];
  int          acc_cnt[2] = '{0, 0};
  int          rsp_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ctrl(r0_ctrl), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ctrl(r1_ctrl), .r1_a(r1_a), .r1_b(r1_b),
    .alu_ctrl(alu_ctrl), .alu_oper1(alu_oper1), .alu_oper2(alu_oper2),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero)
  );

  // Returns {overflow, zero, result}: 0 add, 1 sub, 2 and, 3 or, else xor.
  function automatic logic [33:0] alu_fn(input logic [CTRL_W-1:0] c,
                                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             ov;
    ov = 1'b0;
    case (c)
      4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      default: r = a ^ b;
    endcase
    return {ov, (r == '0), r};
  endfunction

  assign {alu_overflow, alu_zero, alu_result} = alu_fn(alu_ctrl, alu_oper1, alu_oper2);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected results are pushed at accept and compared when the response handshakes.
  task automatic monitor();
    logic [34:0] e;
    logic [34:0] got;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (r0_valid && r0_ready) begin
          exp_q.push_back({1'b0, alu_fn(r0_ctrl, r0_a, r0_b)});
          grant_log.push_back(0);
          acc_cnt[0]++;
          $display("acc id=0 ctrl=%0d a=0x%08h b=0x%08h", r0_ctrl, r0_a, r0_b);
        end
        if (r1_valid && r1_ready) begin
          exp_q.push_back({1'b1, alu_fn(r1_ctrl, r1_a, r1_b)});
          grant_log.push_back(1);
          acc_cnt[1]++;
          $display("acc id=1 ctrl=%0d a=0x%08h b=0x%08h", r1_ctrl, r1_a, r1_b);
        end
        if (rsp_valid && rsp_ready) begin
          got = {rsp_id, rsp_overflow, rsp_zero, rsp_result};
          rsp_log.push_back(got);
          rsp_cnt++;
          $display("rsp id=%0d result=0x%08h ovf=%0d zero=%0d", rsp_id, rsp_result, rsp_overflow, rsp_zero);
          if (exp_q.size() == 0) begin
            check("sb_unexpected", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("sb_rsp", 64'(got), 64'(e));
          end
        end
      end
    end
  endtask

  task automatic set_req(input int id, input logic [CTRL_W-1:0] c,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (id == 0) begin
      r0_valid = 1'b1; r0_ctrl = c; r0_a = a; r0_b = b;
    end else begin
      r1_valid = 1'b1; r1_ctrl = c; r1_a = a; r1_b = b;
    end
  endtask

  task automatic rand_req(input int id);
    set_req(id, CTRL_W'($urandom_range(0, 4)), $urandom, $urandom);
  endtask

  // Holds current requests until n accepts are seen; accepted requesters drop or reload.
  task automatic hold_until_accept(input int n, input bit reload, input int budget);
    int base0, base1, seen0, seen1;
    base0 = acc_cnt[0]; base1 = acc_cnt[1];
    seen0 = base0; seen1 = base1;
    while (((acc_cnt[0] - base0) + (acc_cnt[1] - base1)) < n && budget > 0) begin
      tick();
      budget--;
      if (acc_cnt[0] != seen0) begin
        seen0 = acc_cnt[0];
        if (reload) rand_req(0); else r0_valid = 1'b0;
      end
      if (acc_cnt[1] != seen1) begin
        seen1 = acc_cnt[1];
        if (reload) rand_req(1); else r1_valid = 1'b0;
      end
    end
    if (((acc_cnt[0] - base0) + (acc_cnt[1] - base1)) < n)
      check("accept_timeout", 64'((acc_cnt[0] - base0) + (acc_cnt[1] - base1)), 64'(n));
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int budget;
    budget = 60;
    while (rsp_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    if (rsp_cnt < target) check("rsp_timeout", 64'(rsp_cnt), 64'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int          base, tgt, acc_before, pre;
    int          budget;
    logic [34:0] snap;
    int          exp_order[4];

`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    rst = 1'b1; rsp_ready = 1'b1;
    r0_valid = 1'b0; r0_ctrl = '0; r0_a = '0; r0_b = '0;
    r1_valid = 1'b0; r1_ctrl = '0; r1_a = '0; r1_b = '0;
    fork
      monitor();
    join_none

    // Reset state
    tick();
    tick();
    check("rst_r0_ready", 64'(r0_ready), 64'd0);
    check("rst_r1_ready", 64'(r1_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("rst_alu_oper1", 64'(alu_oper1), 64'd0);
    check("rst_alu_oper2", 64'(alu_oper2), 64'd0);
    check("rst_rsp_data", 64'({rsp_id, rsp_overflow, rsp_zero, rsp_result}), 64'd0);
    rst = 1'b0;

    // Single add 1+1 and its latency
    set_req(0, 4'd0, 32'd1, 32'd1);
    #1;
    check("t2_r0_ready", 64'(r0_ready), 64'd1);
    check("t2_r1_ready", 64'(r1_ready), 64'd0);
    tick();
    r0_valid = 1'b0;
    #1;
    check("t2_rsp_early", 64'(rsp_valid), 64'd0);
    tick();
    check("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t2_rsp_id", 64'(rsp_id), 64'd0);
    check("t2_rsp_result", 64'(rsp_result), 64'd2);
    check("t2_rsp_flags", 64'({rsp_overflow, rsp_zero}), 64'd0);
    wait_rsp(1);

    // Both valid from reset: zero flag, then signed overflow
    do_reset();
    base = rsp_log.size();
    tgt = rsp_cnt + 2;
    set_req(0, 4'd0, 32'd3, 32'hFFFF_FFFD);
    set_req(1, 4'd0, 32'h7FFF_FFFF, 32'd1);
    hold_until_accept(2, 1'b0, 20);
    wait_rsp(tgt);
    check("t3_rsp_count", 64'(rsp_log.size() - base), 64'd2);
    if (rsp_log.size() >= base + 2) begin
      check("t3_first", 64'(rsp_log[base]), 64'({1'b0, 1'b0, 1'b1, 32'h0000_0000}));
      check("t3_second", 64'(rsp_log[base + 1]), 64'({1'b1, 1'b1, 1'b0, 32'h8000_0000}));
    end

    // Both held valid for four ops
    do_reset();
    base = grant_log.size();
    tgt = rsp_cnt + 4;
    rand_req(0);
    rand_req(1);
    hold_until_accept(4, 1'b1, 60);
    wait_rsp(tgt);
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > base + i)
        check($sformatf("t4_grant%0d", i), 64'(grant_log[base + i]), 64'(exp_order[i]));
      else
        check($sformatf("t4_grant%0d_missing", i), 64'(grant_log.size()), 64'(base + i + 1));
    end

    // Response back-pressure
    rsp_ready = 1'b0;
    tgt = rsp_cnt + 1;
    rand_req(0);
    hold_until_accept(1, 1'b0, 10);
    budget = 10;
    while (!rsp_valid && budget > 0) begin
      tick();
      budget--;
    end
    check("t5_rsp_valid", 64'(rsp_valid), 64'd1);
    snap = {rsp_id, rsp_overflow, rsp_zero, rsp_result};
    rand_req(0);
    rand_req(1);
    acc_before = acc_cnt[0] + acc_cnt[1];
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_hold%0d", i), 64'({rsp_valid, rsp_id, rsp_overflow, rsp_zero, rsp_result}),
            64'({1'b1, snap}));
      check($sformatf("t5_ready%0d", i), 64'({r1_ready, r0_ready}), 64'd0);
    end
    check("t5_no_accept", 64'(acc_cnt[0] + acc_cnt[1]), 64'(acc_before));
    rsp_ready = 1'b1;
    tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
    check("t5_idle_grant", 64'({r1_ready, r0_ready}), 64'b01);
`else
    check("t5_idle_grant", 64'({r1_ready, r0_ready}), 64'b10);
`endif
    check("t5_rsp_count", 64'(rsp_cnt), 64'(tgt));
    tgt = rsp_cnt + 2;
    hold_until_accept(2, 1'b0, 20);
    wait_rsp(tgt);

    // Reset while an op is executing
    do_reset();
    rand_req(0);
    hold_until_accept(1, 1'b0, 10);
    pre = rsp_cnt;
    rst = 1'b1;
    rand_req(1);
    tick();
    check("t6_rsp_valid_a", 64'(rsp_valid), 64'd0);
    tick();
    check("t6_rsp_valid_b", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    rand_req(0);
    #1;
    check("t6_last_grant", 64'({r1_ready, r0_ready}), 64'b01);
    check("t6_no_rsp", 64'(rsp_cnt), 64'(pre));
    base = grant_log.size();
    tgt = rsp_cnt + 2;
    hold_until_accept(2, 1'b0, 20);
    wait_rsp(tgt);
    if (grant_log.size() >= base + 2)
      check("t6_r1_granted", 64'(grant_log[base + 1]), 64'd1);
    else
      check("t6_r1_missing", 64'(grant_log.size()), 64'(base + 2));

    tick();
    tick();
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
